tile_cursor: RTL
================

TILE_CURSOR -- requirements
Module: tile_cursor

Interface
REQ-001 Parameter HP, 1920: active pixels per line.
REQ-002 Parameter VP, 1080: active lines per frame.
REQ-003 Parameter KH_MAX, 64: maximum tile width in pixels.
REQ-004 Parameter KV_MAX, 64: maximum tile height in lines.
REQ-005 Parameter HBLKS, 64: tile columns per frame.
REQ-006 Parameter VBLKS, 36: tile rows per frame.
REQ-007 Parameter SYNC_POL, 1'b1: active level of hs_i/vs_i; internal hs/vs = input XNOR SYNC_POL.
REQ-008 Parameter FW, 8: frame counter width.
REQ-009 clk_i  in  1  pixel clock; one clock, all logic on its rising edge.
REQ-010 rst_ni  in  1  reset, asynchronous, active-low.
REQ-011 hs_i, vs_i, de_i  in  1 each  video timing.
REQ-012 kh_i  in  clog2(KH_MAX+1)  requested tile width.
REQ-013 kv_i  in  clog2(KV_MAX+1)  requested tile height.
REQ-014 de_fall_o  out  1  de_i high last cycle, low this cycle.
REQ-015 h_save_o, v_save_o  out  1 each  last pixel of a tile column / last line of a tile row.
REQ-016 ht_cur_o, vt_cur_o  out  clog2(HBLKS), clog2(VBLKS)  current tile column/row.
REQ-017 hp_o, vp_o  out  clog2(KH_MAX), clog2(KV_MAX)  pixel/line offset inside the tile.
REQ-018 tile_idx_o  out  clog2(HBLKS*VBLKS)  vt_cur_o*HBLKS + ht_cur_o, registered with them.
REQ-019 frame_end_o  out  1  one-cycle pulse at the de_fall_o of line VP-1.
REQ-020 frame_cnt_o  out  FW  completed frames, wraps modulo 2^FW.
REQ-021 ovf_o  out  1  sticky: tiles exceeded HBLKS or VBLKS this frame.

Function
REQ-022 Internal column counter hx counts de_i cycles and clears while internal hs is active; line counter vx increments on de_fall_o and clears while internal vs is active.
REQ-023 kh_q/kv_q SHALL be sampled each cycle internal vs is active, clamped to 1..KH_MAX / 1..KV_MAX (0 becomes 1); values are constant for the rest of the frame.
REQ-024 h_save_o = de_i && (hp_o==kh_q-1 || hx==HP-1), combinational.
REQ-025 v_save_o = de_fall_o && (vp_o==kv_q-1 || vx==VP-1), combinational.
REQ-026 hp_o: +1 per de_i cycle, 0 after h_save_o or while de_i low; vp_o: +1 per de_fall_o, 0 after v_save_o; both 0 during vs.
REQ-027 ht_cur_o: 0 while de_i low; +1 after h_save_o, saturating at HBLKS-1 and setting ovf_o on an attempted step beyond.
REQ-028 vt_cur_o: +1 after v_save_o, same saturation/ovf_o rule against VBLKS-1; 0 during vs.
REQ-029 frame_end_o = de_fall_o && vx==VP-1; frame_cnt_o increments the cycle after; ovf_o clears during vs.
REQ-030 Internal hs and de_i high together: hs wins, and hx clears.
REQ-031 The last tile of a row/column SHALL be partial when HP/VP is not a multiple of the tile size, and SHALL be closed by the HP-1/VP-1 term.

Reset
REQ-032 rst_ni low SHALL asynchronously clear all counters, ht/vt/hp/vp/tile_idx, frame_cnt_o, ovf_o, and the de_i delay register; kh_q=KH_MAX, kv_q=KV_MAX.
REQ-033 Reset mid-frame: outputs stay 0 until the next vs; no save or frame_end pulse is issued for the partial frame.

Structure
REQ-034 A shared package SHALL hold the default geometry constants and the clog2-derived widths.
REQ-035 A sub-module tile_axis_counter (offset, tile index, saturation, ovf) SHALL be instantiated once per axis.

Verification
REQ-036 HP=8, kh=3, HBLKS=4: one line -> h_save_o at pixels 2,5,7; ht_cur_o 0,1,2; hp_o sequence 0,1,2,0,1,2,0,1.
REQ-037 VP=6, kv=2: frame -> v_save_o on lines 1,3,5; frame_end_o once on line 5; frame_cnt_o 0->1.
REQ-038 kh=1, HBLKS=4, HP=8 -> ht_cur_o saturates at 3, ovf_o=1; next vs clears ovf_o.
REQ-039 kh_i changed 3->4 mid-frame -> tiling unchanged until the next vs, then 4-pixel tiles.
REQ-040 rst_ni low on line 3 -> all outputs 0 at once, no frame_end_o; normal tiling resumes after the next vs.
REQ-041 SYNC_POL=0, kh_i=0 -> active-low syncs honoured; tile width 1.

Source files
------------

// File: rtl/tile_cursor_pkg.sv
// Shared geometry defaults and the widths derived from them.
package tile_cursor_pkg;

  localparam int unsigned DefHp    = 1920;
  localparam int unsigned DefVp    = 1080;
  localparam int unsigned DefKhMax = 64;
  localparam int unsigned DefKvMax = 64;
  localparam int unsigned DefHblks = 64;
  localparam int unsigned DefVblks = 36;
  localparam int unsigned DefFw    = 8;

  localparam int unsigned DefKhW   = $clog2(DefKhMax + 1);
  localparam int unsigned DefKvW   = $clog2(DefKvMax + 1);
  localparam int unsigned DefHpW   = $clog2(DefKhMax);
  localparam int unsigned DefVpW   = $clog2(DefKvMax);
  localparam int unsigned DefHtW   = $clog2(DefHblks);
  localparam int unsigned DefVtW   = $clog2(DefVblks);
  localparam int unsigned DefIdxW  = $clog2(DefHblks * DefVblks);

endpackage

// File: rtl/tile_cursor_if.sv
// Video timing bundle: sync and data-enable strobes from the timing source.
interface tile_cursor_if;
  logic hs;
  logic vs;
  logic de;

  modport master (output hs, output vs, output de);
  modport slave  (input hs, input vs, input de);
endinterface

// File: rtl/tile_axis_counter.sv
// One tiling axis: offset inside the tile, tile index with saturation, sticky overflow.
module tile_axis_counter #(
  parameter int unsigned KMax  = 64,
  parameter int unsigned NBlks = 64,
  parameter int unsigned SW    = $clog2(KMax + 1),
  parameter int unsigned OW    = $clog2(KMax),
  parameter int unsigned XW    = $clog2(NBlks)
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          clr_i,      // hold offset and index at zero
  input  logic          adv_i,      // one pixel / one line elapsed
  input  logic          last_i,     // this unit is the last of the line / frame
  input  logic          ovf_clr_i,
  input  logic [SW-1:0] size_i,     // tile size, already clamped to 1..KMax
  output logic          save_o,
  output logic [OW-1:0] off_o,
  output logic [XW-1:0] idx_o,
  output logic [XW-1:0] idx_d_o,
  output logic          ovf_o
);

  logic [OW-1:0] off_q, off_d;
  logic [XW-1:0] idx_q, idx_d;
  logic          ovf_q, ovf_d;
  logic          at_end;

  // The line/frame end closes a partial tile as well as a full one.
  assign save_o = adv_i && !clr_i && ((SW'(off_q) == size_i - SW'(1)) || last_i);
  assign at_end = (idx_q == XW'(NBlks - 1));

  // Next-state for offset, tile index and overflow flag.
  always_comb begin
    off_d = off_q;
    idx_d = idx_q;
    ovf_d = ovf_q;
    if (clr_i) begin
      off_d = '0;
      idx_d = '0;
    end else if (adv_i) begin
      if (save_o) begin
        off_d = '0;
        // No step after the final tile: an exact fit must not flag overflow.
        if (last_i) begin
          idx_d = '0;
        end else if (at_end) begin
          ovf_d = 1'b1;
        end else begin
          idx_d = idx_q + XW'(1);
        end
      end else begin
        off_d = off_q + OW'(1);
      end
    end
    if (ovf_clr_i) begin
      ovf_d = 1'b0;
    end
  end

  // Axis state registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      off_q <= '0;
      idx_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      off_q <= off_d;
      idx_q <= idx_d;
      ovf_q <= ovf_d;
    end
  end

  assign off_o   = off_q;
  assign idx_o   = idx_q;
  assign idx_d_o = idx_d;
  assign ovf_o   = ovf_q;

endmodule

// File: rtl/tile_cursor.sv
// Tracks the current tile and in-tile offset of the video raster.
module tile_cursor
  import tile_cursor_pkg::*;
#(
  parameter int unsigned HP       = DefHp,
  parameter int unsigned VP       = DefVp,
  parameter int unsigned KH_MAX   = DefKhMax,
  parameter int unsigned KV_MAX   = DefKvMax,
  parameter int unsigned HBLKS    = DefHblks,
  parameter int unsigned VBLKS    = DefVblks,
  parameter logic        SYNC_POL = 1'b1,
  parameter int unsigned FW       = DefFw,
  localparam int unsigned KhW     = $clog2(KH_MAX + 1),
  localparam int unsigned KvW     = $clog2(KV_MAX + 1),
  localparam int unsigned HpW     = $clog2(KH_MAX),
  localparam int unsigned VpW     = $clog2(KV_MAX),
  localparam int unsigned HtW     = $clog2(HBLKS),
  localparam int unsigned VtW     = $clog2(VBLKS),
  localparam int unsigned IdxW    = $clog2(HBLKS * VBLKS)
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  tile_cursor_if.slave    vid,
  input  logic [KhW-1:0]  kh_i,
  input  logic [KvW-1:0]  kv_i,
  output logic            de_fall_o,
  output logic            h_save_o,
  output logic            v_save_o,
  output logic [HtW-1:0]  ht_cur_o,
  output logic [VtW-1:0]  vt_cur_o,
  output logic [HpW-1:0]  hp_o,
  output logic [VpW-1:0]  vp_o,
  output logic [IdxW-1:0] tile_idx_o,
  output logic            frame_end_o,
  output logic [FW-1:0]   frame_cnt_o,
  output logic            ovf_o
);

  localparam int unsigned HxW = $clog2(HP + 1);
  localparam int unsigned VxW = $clog2(VP + 1);

  logic            hs, vs, vs_eff, de_m, de_q, de_fall;
  logic            armed_q;
  logic [HxW-1:0]  hx_q, hx_d;
  logic [VxW-1:0]  vx_q, vx_d;
  logic [KhW-1:0]  kh_q, kh_c;
  logic [KvW-1:0]  kv_q, kv_c;
  logic [FW-1:0]   frame_cnt_q;
  logic [IdxW-1:0] tile_idx_q;
  logic [HtW-1:0]  ht_d;
  logic [VtW-1:0]  vt_d;
  logic            h_last, v_last, ovf_h, ovf_v;

  assign hs = vid.hs ~^ SYNC_POL;
  assign vs = vid.vs ~^ SYNC_POL;

  // Until a vs is seen after reset, the raster position is unknown: hold everything cleared.
  assign vs_eff  = vs || !armed_q;
  // hs overrides de; nothing counts before the first vs.
  assign de_m    = vid.de && !hs && armed_q;
  assign de_fall = de_q && !de_m;

  assign h_last = (hx_q == HxW'(HP - 1));
  assign v_last = (vx_q == VxW'(VP - 1));

  // Clamp requested tile sizes into 1..MAX.
  always_comb begin
    kh_c = kh_i;
    kv_c = kv_i;
    if (kh_i == '0) begin
      kh_c = KhW'(1);
    end else if (kh_i > KhW'(KH_MAX)) begin
      kh_c = KhW'(KH_MAX);
    end
    if (kv_i == '0) begin
      kv_c = KvW'(1);
    end else if (kv_i > KvW'(KV_MAX)) begin
      kv_c = KvW'(KV_MAX);
    end
  end

  // Raster position counters.
  always_comb begin
    hx_d = hx_q;
    vx_d = vx_q;
    if (hs || !armed_q) begin
      hx_d = '0;
    end else if (de_m) begin
      hx_d = hx_q + HxW'(1);
    end
    if (vs_eff) begin
      vx_d = '0;
    end else if (de_fall) begin
      vx_d = vx_q + VxW'(1);
    end
  end

  tile_axis_counter #(
    .KMax  (KH_MAX),
    .NBlks (HBLKS),
    .SW    (KhW),
    .OW    (HpW),
    .XW    (HtW)
  ) u_h_axis (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .clr_i     (!de_m || vs_eff),
    .adv_i     (de_m),
    .last_i    (h_last),
    .ovf_clr_i (vs_eff),
    .size_i    (kh_q),
    .save_o    (h_save_o),
    .off_o     (hp_o),
    .idx_o     (ht_cur_o),
    .idx_d_o   (ht_d),
    .ovf_o     (ovf_h)
  );

  tile_axis_counter #(
    .KMax  (KV_MAX),
    .NBlks (VBLKS),
    .SW    (KvW),
    .OW    (VpW),
    .XW    (VtW)
  ) u_v_axis (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .clr_i     (vs_eff),
    .adv_i     (de_fall),
    .last_i    (v_last),
    .ovf_clr_i (vs_eff),
    .size_i    (kv_q),
    .save_o    (v_save_o),
    .off_o     (vp_o),
    .idx_o     (vt_cur_o),
    .idx_d_o   (vt_d),
    .ovf_o     (ovf_v)
  );

  assign frame_end_o = de_fall && !vs_eff && v_last;

  // Frame-level state: de delay, arming, tile sizes latched during vs, frame count, linear index.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      de_q        <= 1'b0;
      armed_q     <= 1'b0;
      hx_q        <= '0;
      vx_q        <= '0;
      kh_q        <= KhW'(KH_MAX);
      kv_q        <= KvW'(KV_MAX);
      frame_cnt_q <= '0;
      tile_idx_q  <= '0;
    end else begin
      de_q       <= de_m;
      armed_q    <= armed_q || vs;
      hx_q       <= hx_d;
      vx_q       <= vx_d;
      tile_idx_q <= IdxW'(vt_d) * IdxW'(HBLKS) + IdxW'(ht_d);
      if (vs) begin
        kh_q <= kh_c;
        kv_q <= kv_c;
      end
      if (frame_end_o) begin
        frame_cnt_q <= frame_cnt_q + FW'(1);
      end
    end
  end

  assign de_fall_o   = de_fall;
  assign frame_cnt_o = frame_cnt_q;
  assign tile_idx_o  = tile_idx_q;
  assign ovf_o       = ovf_h || ovf_v;

endmodule
